jt49_multi: RTL

- Parametrised successor PSG core: CH square-tone channels (3..8), one shared noise generator, one shared envelope generator.
- 5-bit register bus with masked readback.
- Outputs a per-channel linearised 8-bit bus and a registered wide sum.
- Sits where the 3-channel PSG sits today, for systems that pair several PSGs or need extra channels without multiple instances.

---
 rtl/jt49_multi_pkg.sv | 26 ++
 rtl/jt49_cen.sv | 32 +++
 rtl/jt49_div.sv | 33 +++
 rtl/jt49_eg.sv | 53 +++++
 rtl/jt49_exp.sv | 31 +++
 rtl/jt49_multi_ch.sv | 54 +++++
 rtl/jt49_noise.sv | 33 +++
 rtl/jt49_multi.sv | 190 +++++++++++++++++++
 8 files changed

// File: rtl/jt49_multi_pkg.sv
// rtl/jt49_multi_pkg.sv - shared constants, types and helpers for the multi-channel PSG
// Contents: register address map, envelope shape fields, volume-to-log conversion.
package jt49_multi_pkg;

    localparam logic [4:0] A_NOISE = 5'h10;
    localparam logic [4:0] A_TDIS  = 5'h11;
    localparam logic [4:0] A_NDIS  = 5'h12;
    localparam logic [4:0] A_VOL0  = 5'h13;
    localparam logic [4:0] A_ENVLO = 5'h1B;
    localparam logic [4:0] A_ENVHI = 5'h1C;
    localparam logic [4:0] A_SHAPE = 5'h1D;

    typedef struct packed {
        logic cont;
        logic att;
        logic alt;
        logic hold;
    } env_shape_t;

    // Fixed 4-bit levels map onto every other step of the 5-bit log scale;
    // repeating the MSB as LSB lets level 15 reach the top step (31).
    function automatic logic [4:0] vol_to_log(input logic [3:0] lvl);
        return {lvl, lvl[3]};
    endfunction

endpackage

// File: rtl/jt49_cen.sv
// rtl/jt49_cen.sv - prescaler producing the 1/16 and 1/256 audio clock enables
// Ports: clk, rst_n, cen (master enable), sel (0 = extra divide by 2), cen16, cen256 (single-cycle pulses).
module jt49_cen (
    input  logic clk,
    input  logic rst_n,
    input  logic cen,
    input  logic sel,
    output logic cen16,
    output logic cen256
);

    logic [8:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cen) begin
            cnt <= cnt + 9'd1;
        end
    end

    always_comb begin
        if (sel) begin
            cen16  = cen & (&cnt[3:0]);
            cen256 = cen & (&cnt[7:0]);
        end else begin
            cen16  = cen & (&cnt[4:0]);
            cen256 = cen & (&cnt[8:0]);
        end
    end

endmodule

// File: rtl/jt49_div.sv
// rtl/jt49_div.sv - programmable square-wave divider
// Ports: clk, rst_n, cen (step enable), period (0 acts as 1), div (toggles once per period steps).
module jt49_div #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cen,
    input  logic [W-1:0] period,
    output logic         div
);

    logic [W-1:0] cnt;
    logic [W-1:0] last;

    assign last = (period == '0) ? '0 : period - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            div <= 1'b0;
        end else if (cen) begin
            // >= rather than == so a period shortened mid-count wraps at once
            if (cnt >= last) begin
                cnt <= '0;
                div <= ~div;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/jt49_eg.sv
// rtl/jt49_eg.sv - 32-step envelope generator
// Ports: clk, rst_n, cen (cen256), step (divider tick), restart, null_period, ctrl (shape), env (5-bit log level).
module jt49_eg
    import jt49_multi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       step,
    input  logic       restart,
    input  logic       null_period,
    input  logic [3:0] ctrl,
    output logic [4:0] env
);

    env_shape_t sh;
    logic [4:0] cnt;
    logic       att;
    logic       stop;

    assign sh  = env_shape_t'(ctrl);
    // att selects rising (count up) or falling (inverted count) slope
    assign env = att ? cnt : ~cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 5'h1F;
            att  <= 1'b0;
            stop <= 1'b1;
        end else if (cen) begin
            if (restart) begin
                cnt  <= 5'd0;
                att  <= sh.att;
                stop <= 1'b0;
            end else if ((step || null_period) && !stop) begin
                if (cnt != 5'h1F) begin
                    cnt <= cnt + 5'd1;
                end else if (!sh.cont) begin
                    // one-shot shapes settle at silence
                    stop <= 1'b1;
                    att  <= 1'b0;
                end else if (sh.hold) begin
                    stop <= 1'b1;
                    if (sh.alt) att <= ~att;
                end else begin
                    if (sh.alt) att <= ~att;
                    cnt <= 5'd0;
                end
            end
        end
    end

endmodule

// File: rtl/jt49_exp.sv
// rtl/jt49_exp.sv - 5-bit log level to 8-bit linear amplitude lookup
// Ports: din (log level, 0 = silence, 31 = full scale), dout (linear level).
module jt49_exp (
    input  logic [4:0] din,
    output logic [7:0] dout
);

    always_comb begin
        dout = 8'd0;
        case (din)
            5'd0:  dout = 8'd0;    5'd1:  dout = 8'd1;
            5'd2:  dout = 8'd1;    5'd3:  dout = 8'd2;
            5'd4:  dout = 8'd2;    5'd5:  dout = 8'd3;
            5'd6:  dout = 8'd3;    5'd7:  dout = 8'd4;
            5'd8:  dout = 8'd5;    5'd9:  dout = 8'd6;
            5'd10: dout = 8'd7;    5'd11: dout = 8'd8;
            5'd12: dout = 8'd9;    5'd13: dout = 8'd11;
            5'd14: dout = 8'd13;   5'd15: dout = 8'd16;
            5'd16: dout = 8'd19;   5'd17: dout = 8'd23;
            5'd18: dout = 8'd27;   5'd19: dout = 8'd32;
            5'd20: dout = 8'd38;   5'd21: dout = 8'd45;
            5'd22: dout = 8'd54;   5'd23: dout = 8'd64;
            5'd24: dout = 8'd76;   5'd25: dout = 8'd90;
            5'd26: dout = 8'd107;  5'd27: dout = 8'd128;
            5'd28: dout = 8'd152;  5'd29: dout = 8'd180;
            5'd30: dout = 8'd214;  5'd31: dout = 8'd255;
            default: dout = 8'd0;
        endcase
    end

endmodule

// File: rtl/jt49_multi_ch.sv
// rtl/jt49_multi_ch.sv - one tone channel: divider, mixer flop, log flop, exp conversion
// Ports: clk, rst_n, clk_en, cen16, period, tone_dis, noise_dis, vol (bit4 = use envelope), env, noise, level.
module jt49_multi_ch
    import jt49_multi_pkg::*;
#(
    parameter int TW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clk_en,
    input  logic          cen16,
    input  logic [TW-1:0] period,
    input  logic          tone_dis,
    input  logic          noise_dis,
    input  logic [4:0]    vol,
    input  logic [4:0]    env,
    input  logic          noise,
    output logic [7:0]    level
);

    logic       tone;
    logic       mix;
    logic [4:0] log_lvl;

    jt49_div #(.W(TW)) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen    (cen16),
        .period (period),
        .div    (tone)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mix     <= 1'b0;
            log_lvl <= 5'd0;
        end else if (clk_en) begin
            // a disable bit forces its source high, so both set gives DC
            mix <= (noise | noise_dis) & (tone | tone_dis);
            if (!mix)
                log_lvl <= 5'd0;
            else if (vol[4])
                log_lvl <= env;
            else
                log_lvl <= vol_to_log(vol[3:0]);
        end
    end

    jt49_exp u_exp (
        .din  (log_lvl),
        .dout (level)
    );

endmodule

// File: rtl/jt49_noise.sv
// rtl/jt49_noise.sv - 17-bit LFSR noise source with 5-bit period divider
// Ports: clk, rst_n, cen (step enable), period (0 acts as 1), noise (LFSR output bit).
module jt49_noise (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic [4:0] period,
    output logic       noise
);

    logic [4:0]  cnt;
    logic [4:0]  last;
    logic [16:0] lfsr;

    assign last  = (period == 5'd0) ? 5'd0 : period - 5'd1;
    assign noise = lfsr[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 5'd0;
            lfsr <= '0;
        end else if (cen) begin
            if (cnt >= last) begin
                cnt <= 5'd0;
                // an all-zero register injects a 1 so the LFSR cannot lock up
                lfsr <= {lfsr[0] ^ lfsr[3] ^ (lfsr == 17'd0), lfsr[16:1]};
            end else begin
                cnt <= cnt + 5'd1;
            end
        end
    end

endmodule

// File: rtl/jt49_multi.sv
// rtl/jt49_multi.sv - parametrised PSG: CH tone channels, shared noise and envelope
// Ports: clk, rst_n (async, active low), clk_en, sel, cs_n/wr_n/addr/din/dout register bus,
//        chan (8 bits per channel, channel k at [8k+7:8k]), sound (registered channel sum).
module jt49_multi
    import jt49_multi_pkg::*;
#(
    parameter int CH = 3,
    parameter int TW = 12,
    parameter int SW = 8 + $clog2(CH) + 1
) (
    input  logic            rst_n,
    input  logic            clk,
    input  logic            clk_en,
    input  logic            sel,
    input  logic            cs_n,
    input  logic            wr_n,
    input  logic [4:0]      addr,
    input  logic [7:0]      din,
    output logic [7:0]      dout,
    output logic [8*CH-1:0] chan,
    output logic [SW-1:0]   sound
);

    logic [7:0]    tone_lo [CH];
    logic [TW-9:0] tone_hi [CH];
    logic [4:0]    vol     [CH];
    logic [4:0]    noise_per;
    logic [CH-1:0] tone_dis;
    logic [CH-1:0] noise_dis;
    logic [7:0]    env_lo;
    logic [7:0]    env_hi;
    logic [3:0]    shape;

    logic [7:0]    rd_data;
    logic          last_strobe;
    logic          restart_req;
    logic          cen16;
    logic          cen256;
    logic          noise;
    logic [15:0]   env_per;
    logic [15:0]   env_cnt;
    logic          env_null;
    logic          env_tick;
    logic [4:0]    env;
    logic [SW-1:0] sum_c;

    // Register file: level-sensitive write on every strobed clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CH; k++) begin
                tone_lo[k] <= '0;
                tone_hi[k] <= '0;
                vol[k]     <= '0;
            end
            noise_per <= '0;
            tone_dis  <= '0;
            noise_dis <= '0;
            env_lo    <= '0;
            env_hi    <= '0;
            shape     <= '0;
        end else if (!cs_n && !wr_n) begin
            for (int k = 0; k < CH; k++) begin
                if (addr == 5'(2 * k))       tone_lo[k] <= din;
                if (addr == 5'(2 * k + 1))   tone_hi[k] <= din[TW-9:0];
                if (addr == A_VOL0 + 5'(k))  vol[k]     <= din[4:0];
            end
            case (addr)
                A_NOISE: noise_per <= din[4:0];
                A_TDIS:  tone_dis  <= din[CH-1:0];
                A_NDIS:  noise_dis <= din[CH-1:0];
                A_ENVLO: env_lo    <= din;
                A_ENVHI: env_hi    <= din;
                A_SHAPE: shape     <= din[3:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data = 8'd0;
        for (int k = 0; k < CH; k++) begin
            if (addr == 5'(2 * k))       rd_data = tone_lo[k];
            if (addr == 5'(2 * k + 1))   rd_data = 8'(tone_hi[k]);
            if (addr == A_VOL0 + 5'(k))  rd_data = 8'(vol[k]);
        end
        case (addr)
            A_NOISE: rd_data = 8'(noise_per);
            A_TDIS:  rd_data = 8'(tone_dis);
            A_NDIS:  rd_data = 8'(noise_dis);
            A_ENVLO: rd_data = env_lo;
            A_ENVHI: rd_data = env_hi;
            A_SHAPE: rd_data = 8'(shape);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= 8'd0;
        end else if (!cs_n) begin
            dout <= rd_data;
        end
    end

    // Restart request: set by a strobe falling edge on the shape register,
    // consumed by the next cen256. A new edge on the consuming clock wins,
    // so back-to-back shape writes are never lost. Runs regardless of clk_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_strobe <= 1'b1;
            restart_req <= 1'b0;
        end else begin
            last_strobe <= cs_n | wr_n;
            restart_req <= (restart_req & ~cen256)
                         | (last_strobe & ~(cs_n | wr_n) & (addr == A_SHAPE));
        end
    end

    jt49_cen u_cen (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen    (clk_en),
        .sel    (sel),
        .cen16  (cen16),
        .cen256 (cen256)
    );

    jt49_noise u_noise (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen    (cen16),
        .period (noise_per),
        .noise  (noise)
    );

    assign env_per  = {env_hi, env_lo};
    assign env_null = (env_per == 16'd0);
    assign env_tick = (env_cnt >= env_per - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            env_cnt <= 16'd0;
        end else if (cen256) begin
            env_cnt <= (env_null || env_tick) ? 16'd0 : env_cnt + 16'd1;
        end
    end

    jt49_eg u_eg (
        .clk         (clk),
        .rst_n       (rst_n),
        .cen         (cen256),
        .step        (env_tick),
        .restart     (restart_req),
        .null_period (env_null),
        .ctrl        (shape),
        .env         (env)
    );

    for (genvar k = 0; k < CH; k++) begin : g_ch
        jt49_multi_ch #(.TW(TW)) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .clk_en    (clk_en),
            .cen16     (cen16),
            .period    ({tone_hi[k], tone_lo[k]}),
            .tone_dis  (tone_dis[k]),
            .noise_dis (noise_dis[k]),
            .vol       (vol[k]),
            .env       (env),
            .noise     (noise),
            .level     (chan[8*k +: 8])
        );
    end

    always_comb begin
        sum_c = '0;
        for (int k = 0; k < CH; k++) begin
            sum_c = sum_c + SW'(chan[8*k +: 8]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sound <= '0;
        end else if (clk_en) begin
            sound <= sum_c;
        end
    end

endmodule
